// File: rtl/seq_detect_prog.sv
// -----------------------------------------------------------------------------
// seq_detect_prog
//
// Run-time programmable serial bit-sequence detector. A pattern of 1..MAX_LEN
// bits is loaded through the cfg_* port. The detector then watches the
// qualified serial stream (a sampled when in_valid is high). It emits a
// registered one-cycle pulse for every match and counts matches in a
// saturating counter. Overlapping or non-overlapping matching is selectable
// per configuration.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; clears all state and config
//   cfg_load     load cfg_pattern/cfg_len/cfg_overlap this cycle
//   cfg_pattern  pattern; bit [len-1] is received first, bit [0] last
//   cfg_len      pattern length; legal range 1..MAX_LEN, anything else disables
//   cfg_overlap  1 = a match suffix may start the next match
//   in_valid     qualifies a
//   a            serial data bit
//   cnt_clr      synchronous clear of match_count (cfg_load takes priority)
//   detected     one-cycle pulse, the cycle after the last pattern bit
//   match_count  saturating match counter
//   enabled      a valid configuration is loaded and detection is active
// -----------------------------------------------------------------------------
module seq_detect_prog #(
  parameter  int MAX_LEN = 16,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               a,
  input  logic               cnt_clr,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               enabled
);

  typedef enum logic {
    ST_DISABLED = 1'b0,
    ST_HUNT     = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t               state_q, state_d;
  logic [MAX_LEN-1:0]   pattern_q;
  logic [LEN_W-1:0]     len_q;
  logic                 overlap_q;
  logic [MAX_LEN-1:0]   history_q;
  logic [LEN_W-1:0]     fill_q;

  logic                 cfg_ok;
  logic                 accept;
  logic [MAX_LEN-1:0]   hist_shift;
  logic [LEN_W-1:0]     fill_inc;
  logic [MAX_LEN-1:0]   len_mask;
  logic                 match;

  // A zero length or one beyond MAX_LEN parks the block in DISABLED.
  assign cfg_ok  = (cfg_len != '0) && (cfg_len <= LEN_MAX);
  assign accept  = in_valid && (state_q == ST_HUNT) && !cfg_load;
  assign enabled = (state_q == ST_HUNT);

  // Next-state logic: only a configuration load moves the FSM.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    if (cfg_load) begin
      state_d = cfg_ok ? ST_HUNT : ST_DISABLED;
    end
  end

  // Match is judged on the values the registers will hold after this edge,
  // so the pulse lands exactly one cycle after the final pattern bit.
  always_comb begin
    hist_shift = {history_q[MAX_LEN-2:0], a};
    fill_inc   = (fill_q == LEN_MAX) ? LEN_MAX : fill_q + 1'b1;
    len_mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    match = accept && (fill_inc >= len_q) &&
            (((hist_shift ^ pattern_q) & len_mask) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: registered state is updated with non-blocking assignments so
      // every flop samples pre-edge values regardless of statement order.
      state_q   <= ST_DISABLED;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cfg_load) begin
        pattern_q <= cfg_pattern;
        len_q     <= cfg_len;
        overlap_q <= cfg_overlap;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      history_q <= '0;
      fill_q    <= '0;
    end else if (cfg_load) begin
      history_q <= '0;
      fill_q    <= '0;
    end else if (accept) begin
      history_q <= hist_shift;
      // Non-overlapping mode restarts the fill so the next match needs a
      // full fresh pattern; stale history bits are then masked by fill.
      fill_q    <= (match && !overlap_q) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      detected    <= 1'b0;
      match_count <= '0;
    end else begin
      detected <= match;
      if (cfg_load || cnt_clr) begin
        match_count <= '0;
      end else if (match && (match_count != CNT_MAX)) begin
        match_count <= match_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
- Parametrised, run-time programmable serial bit-sequence detector. Successor to the fixed-pattern FSM detectors.
- Pattern, pattern length (1..MAX_LEN) and overlap/non-overlap mode are loaded at run time. Adds an input-valid qualifier and a saturating match counter.
- Sits on the serial bit stream feeding protocol/frame-sync logic. Produces a one-cycle detect pulse per match.

Parameters:
MAX_LEN, 16, maximum pattern length in bits (>=2)
LEN_W, $clog2(MAX_LEN+1), width of length field (derived, not overridden)
CNT_W, 8, width of saturating match counter

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cfg_load  input  1  load cfg_* fields this cycle
cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is first bit received, bit [0] is last; bits >= len ignored
cfg_len  input  LEN_W  pattern length
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping
in_valid  input  1  a is sampled only when high
a  input  1  serial data bit
cnt_clr  input  1  synchronous clear of match_count
detected  output  1  registered one-cycle match pulse
match_count  output  CNT_W  saturating number of matches since last clear/load
enabled  output  1  high when the loaded configuration is valid (state HUNT)

Behaviour:
- Reset (async, rst_n=0): state DISABLED, stored pattern=0, len=0, overlap=0, history=0, fill=0, detected=0, match_count=0, enabled=0.
- State machine, 2 states:
  - DISABLED: no detection.
  - HUNT: detecting.
  - cfg_load with 1<=cfg_len<=MAX_LEN -> HUNT. cfg_load with cfg_len==0 or cfg_len>MAX_LEN -> DISABLED. No other transitions.
- cfg_load cycle, in any state:
  - Latch pattern/len/overlap.
  - Clear history, fill and match_count.
  - detected=0 next cycle.
  - in_valid and a are ignored that cycle.
  - cfg_load has priority over cnt_clr and input acceptance.
- Accepted bit = posedge with in_valid=1, state HUNT, cfg_load=0:
  - history <= {history[MAX_LEN-2:0], a}.
  - fill <= min(fill+1, MAX_LEN).
- Match condition, evaluated on the post-shift values: (new_fill >= len) and (new_history[len-1:0] == pattern[len-1:0]).
- Latency:
  - detected is high for exactly the cycle following the edge that accepted the last pattern bit. It is registered, no combinational path from a.
  - detected is 0 in every cycle not directly following a matching accepted bit. in_valid=0 cycles leave history and fill unchanged and give detected=0.
- Overlap mode:
  - cfg_overlap=1: history and fill are kept after a match. A suffix of the match may start the next match.
  - cfg_overlap=0: fill <= 0 on the match edge. History content is irrelevant until fill again reaches len.
- match_count:
  - Increments by 1 on each match edge and saturates at 2^CNT_W-1. It does not wrap.
  - cnt_clr=1 sets it to 0. If cnt_clr and a match occur on the same edge, the result is 0; the detected pulse is still produced.
- len==1 is legal: every accepted bit equal to pattern[0] matches.
- Reset asserted mid-sequence: all state is cleared immediately, the configuration is lost, and the block stays DISABLED until the next cfg_load.

Test Plan:
- Reset, then cfg_load pattern=6'b110011, len=6, overlap=1. Stream 1,1,0,0,1,1,0,0,1,1 (in_valid=1) -> detected pulses the cycle after bit 6 and after bit 10; match_count=2; enabled=1.
- Pattern 4'b1010, len=4, stream 1,0,1,0,1,0,1,0. overlap=1 -> pulses after bits 4, 6, 8, count=3. Repeat with overlap=0 -> pulses after bits 4 and 8 only, count=2.
- Pattern 1010 with in_valid low for 3 cycles between bits 2 and 3 -> single pulse after the 4th accepted bit; detected=0 during gaps.
- cfg_len=0, then cfg_len=17 (MAX_LEN=16), each followed by 20 random valid bits -> enabled=0, detected never high, match_count=0.
- CNT_W=2, len=1, pattern=1, stream of six 1s -> six pulses, match_count stops at 3. cnt_clr asserted on the 6th match edge -> count 0, pulse still seen.
- rst_n pulsed low asynchronously after 3 bits of 110011 -> outputs 0 immediately. After release, the next bits give no detection until cfg_load; after reload, a full 110011 detects again.
